// File: rtl/div_issue_arbiter.sv
// Round-robin issue arbiter that shares one iterative 64-bit divider between
// NUM_REQ reservation stations and holds each result until writeback accepts it.
module div_issue_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ROBsize    = 32,
   parameter int ROBsizeLog = $clog2(ROBsize + 1)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic [NUM_REQ-1:0]            readyRS_i,
   input  logic [NUM_REQ*64-1:0]         reservationStationVal1_i,
   input  logic [NUM_REQ*64-1:0]         reservationStationVal2_i,
   input  logic [NUM_REQ*10-1:0]         reservationStationCommands_i,
   input  logic [NUM_REQ*ROBsizeLog-1:0] reservationStationTag_i,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          divValidIn_o,
   output logic [63:0]                   divDividend_o,
   output logic [63:0]                   divDivisor_o,
   input  logic                          divValidOut_i,
   input  logic [63:0]                   divQuotient_i,
   input  logic                          flush_i,
   input  logic                          canGo_i,
   output logic                          valid_o,
   output logic [63:0]                   executeVal_o,
   output logic [9:0]                    executeCommands_o,
   output logic [ROBsizeLog-1:0]         executeTag_o,
   output logic [3:0]                    executeFlags_o,
   output logic                          busy_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [PTR_W-1:0]       rr_q, rr_d;
   logic                   kill_q, kill_d;
   logic [9:0]             cmd_q, cmd_d;
   logic [ROBsizeLog-1:0]  tag_q, tag_d;
   logic                   zero_q, zero_d;
   logic [63:0]            val_q, val_d;
   logic [9:0]             ecmd_q, ecmd_d;
   logic [ROBsizeLog-1:0]  etag_q, etag_d;
   logic [3:0]             flag_q, flag_d;

   logic                   gnt_any;
   logic [PTR_W-1:0]       gnt_idx;
   int                     scan_idx;

   // Scan stations starting at rrPtr; the first ready one wins.
   always_comb begin
      gnt_any  = 1'b0;
      gnt_idx  = '0;
      scan_idx = 0;
      grant_o  = '0;
      if (state_q == IDLE && !flush_i) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            if (!gnt_any && readyRS_i[scan_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = PTR_W'(scan_idx);
            end
         end
      end
      if (gnt_any) grant_o[gnt_idx] = 1'b1;
   end

   assign divValidIn_o  = gnt_any;
   assign divDividend_o = gnt_any ? reservationStationVal1_i[int'(gnt_idx)*64 +: 64] : 64'd0;
   assign divDivisor_o  = gnt_any ? reservationStationVal2_i[int'(gnt_idx)*64 +: 64] : 64'd0;
   assign busy_o        = (state_q != IDLE);
   assign valid_o       = (state_q == DONE);

   assign executeVal_o      = val_q;
   assign executeCommands_o = ecmd_q;
   assign executeTag_o      = etag_q;
   assign executeFlags_o    = flag_q;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      kill_d  = kill_q;
      cmd_d   = cmd_q;
      tag_d   = tag_q;
      zero_d  = zero_q;
      val_d   = val_q;
      ecmd_d  = ecmd_q;
      etag_d  = etag_q;
      flag_d  = flag_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               cmd_d   = reservationStationCommands_i[int'(gnt_idx)*10 +: 10];
               tag_d   = reservationStationTag_i[int'(gnt_idx)*ROBsizeLog +: ROBsizeLog];
               zero_d  = (divDivisor_o == 64'd0);
               rr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
               state_d = BUSY;
            end
         end
         BUSY: begin
            // The divider cannot be aborted, so a flushed op drains here.
            if (divValidOut_i) begin
               if (kill_q || flush_i) begin
                  kill_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  val_d   = divQuotient_i;
                  flag_d  = {3'b000, zero_q};
                  ecmd_d  = cmd_q;
                  etag_d  = tag_q;
                  state_d = DONE;
               end
            end else if (flush_i) begin
               kill_d = 1'b1;
            end
         end
         DONE: begin
            if (flush_i || canGo_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         rr_q    <= '0;
         kill_q  <= 1'b0;
         cmd_q   <= '0;
         tag_q   <= '0;
         zero_q  <= 1'b0;
         val_q   <= '0;
         ecmd_q  <= '0;
         etag_q  <= '0;
         flag_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         kill_q  <= kill_d;
         cmd_q   <= cmd_d;
         tag_q   <= tag_d;
         zero_q  <= zero_d;
         val_q   <= val_d;
         ecmd_q  <= ecmd_d;
         etag_q  <= etag_d;
         flag_q  <= flag_d;
      end
   end

endmodule

// File: tb/tb_div_issue_arbiter.sv
// Self-checking bench for div_issue_arbiter; the bench plays the divider and
// predicts grants and results from the round-robin and division rules.
module tb_div_issue_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ROBsize = 32;
   localparam int TW      = $clog2(ROBsize + 1);

   logic                   clk_i = 1'b0;
   logic                   reset_i;
   logic [NUM_REQ-1:0]     readyRS_i;
   logic [NUM_REQ*64-1:0]  val1, val2;
   logic [NUM_REQ*10-1:0]  cmds;
   logic [NUM_REQ*TW-1:0]  tags;
   logic [NUM_REQ-1:0]     grant_o;
   logic                   divValidIn_o;
   logic [63:0]            divDividend_o, divDivisor_o;
   logic                   divValidOut_i;
   logic [63:0]            divQuotient_i;
   logic                   flush_i, canGo_i;
   logic                   valid_o;
   logic [63:0]            executeVal_o;
   logic [9:0]             executeCommands_o;
   logic [TW-1:0]          executeTag_o;
   logic [3:0]             executeFlags_o;
   logic                   busy_o;

   int checks = 0;
   int errors = 0;
   int rr_m   = 0;

   logic [63:0]   a_s [NUM_REQ];
   logic [63:0]   b_s [NUM_REQ];
   logic [9:0]    c_s [NUM_REQ];
   logic [TW-1:0] t_s [NUM_REQ];

   div_issue_arbiter #(.NUM_REQ(NUM_REQ), .ROBsize(ROBsize)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .readyRS_i(readyRS_i),
      .reservationStationVal1_i(val1), .reservationStationVal2_i(val2),
      .reservationStationCommands_i(cmds), .reservationStationTag_i(tags),
      .grant_o(grant_o), .divValidIn_o(divValidIn_o),
      .divDividend_o(divDividend_o), .divDivisor_o(divDivisor_o),
      .divValidOut_i(divValidOut_i), .divQuotient_i(divQuotient_i),
      .flush_i(flush_i), .canGo_i(canGo_i), .valid_o(valid_o),
      .executeVal_o(executeVal_o), .executeCommands_o(executeCommands_o),
      .executeTag_o(executeTag_o), .executeFlags_o(executeFlags_o),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: the divider returns all ones on a zero divisor.
   function automatic logic [63:0] div_model(input logic [63:0] a, input logic [63:0] b);
      return (b == 64'd0) ? '1 : a / b;
   endfunction

   // Reference: first ready station at or after the round-robin pointer.
   function automatic int exp_gnt(input logic [NUM_REQ-1:0] rdy);
      for (int k = 0; k < NUM_REQ; k++)
         if (rdy[(rr_m + k) % NUM_REQ]) return (rr_m + k) % NUM_REQ;
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int i);
      logic [NUM_REQ-1:0] v;
      v = '0;
      if (i >= 0) v[i] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_station(input int i, input logic [63:0] a, input logic [63:0] b,
                              input logic [9:0] c, input logic [TW-1:0] t);
      a_s[i] = a; b_s[i] = b; c_s[i] = c; t_s[i] = t;
      val1[64*i +: 64] = a;
      val2[64*i +: 64] = b;
      cmds[10*i +: 10] = c;
      tags[TW*i +: TW] = t;
   endtask

   task automatic pulse_div(input logic [63:0] q);
      divValidOut_i = 1'b1;
      divQuotient_i = q;
      tick();
      divValidOut_i = 1'b0;
      #1;
   endtask

   task automatic apply_reset();
      #2;
      reset_i = 1'b1;
      #3;
      reset_i = 1'b0;
      rr_m = 0;
      tick();
   endtask

   task automatic test_reset();
      reset_i = 1'b1; readyRS_i = '0; val1 = '0; val2 = '0; cmds = '0; tags = '0;
      divValidOut_i = 1'b0; divQuotient_i = '0; flush_i = 1'b0; canGo_i = 1'b0;
      #7;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
      checks++; if ({grant_o, divValidIn_o} !== '0) begin errors++; $display("FAIL reset_grant got %b/%b exp 0", grant_o, divValidIn_o); end
      checks++; if ({executeVal_o, executeCommands_o, executeTag_o, executeFlags_o} !== '0) begin
         errors++; $display("FAIL reset_fields got %h/%h/%h/%h exp 0", executeVal_o, executeCommands_o, executeTag_o, executeFlags_o); end
      reset_i = 1'b0;
      rr_m = 0;
      tick();
   endtask

   task automatic test_single();
      set_station(0, 64'd15, 64'd3, 10'd10, TW'(3));
      readyRS_i = 2'b01;
      #1;
      checks++; if (grant_o !== 2'b01 || divValidIn_o !== 1'b1) begin errors++; $display("FAIL single_grant got %b/%b exp 01/1", grant_o, divValidIn_o); end
      checks++; if (divDividend_o !== 64'd15 || divDivisor_o !== 64'd3) begin errors++; $display("FAIL single_operands got %0d/%0d exp 15/3", divDividend_o, divDivisor_o); end
      tick();
      rr_m = 1;
      checks++; if (grant_o !== 2'b00 || busy_o !== 1'b1) begin errors++; $display("FAIL single_busy grant %b busy %b exp 00/1", grant_o, busy_o); end
      readyRS_i = '0;
      repeat (4) tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b exp 0", valid_o); end
      pulse_div(div_model(64'd15, 64'd3));
      checks++; if (valid_o !== 1'b1 || executeVal_o !== 64'd5) begin errors++; $display("FAIL single_result valid %b val %0d exp 1/5", valid_o, executeVal_o); end
      checks++; if (executeTag_o !== TW'(3) || executeCommands_o !== 10'd10 || executeFlags_o !== 4'd0) begin
         errors++; $display("FAIL single_fields tag %0d cmd %0d flags %b exp 3/10/0000", executeTag_o, executeCommands_o, executeFlags_o); end
      divQuotient_i = 64'hDEAD_BEEF_0000_1234;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (valid_o !== 1'b1 || executeVal_o !== 64'd5 || executeTag_o !== TW'(3)) begin
            errors++; $display("FAIL single_hold cycle %0d valid %b val %0d tag %0d exp 1/5/3", i, valid_o, executeVal_o, executeTag_o); end
      end
      canGo_i = 1'b1;
      tick();
      canGo_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL single_release valid %b busy %b exp 0/0", valid_o, busy_o); end
   endtask

   task automatic test_round_robin();
      int e;
      apply_reset();
      set_station(0, 64'd100, 64'd10, 10'd1, TW'(5));
      set_station(1, 64'd81, 64'd9, 10'd2, TW'(6));
      readyRS_i = 2'b11;
      canGo_i = 1'b1;
      #1;
      for (int n = 0; n < 4; n++) begin
         e = exp_gnt(readyRS_i);
         checks++; if (grant_o !== onehot(e) || divDividend_o !== a_s[e]) begin
            errors++; $display("FAIL rr_grant op %0d got %b/%0d exp %b/%0d", n, grant_o, divDividend_o, onehot(e), a_s[e]); end
         rr_m = (e + 1) % NUM_REQ;
         tick();
         repeat (2) tick();
         pulse_div(div_model(a_s[e], b_s[e]));
         checks++; if (valid_o !== 1'b1 || executeVal_o !== div_model(a_s[e], b_s[e]) || executeTag_o !== t_s[e]) begin
            errors++; $display("FAIL rr_result op %0d valid %b val %0d tag %0d exp 1/%0d/%0d", n, valid_o, executeVal_o, executeTag_o, div_model(a_s[e], b_s[e]), t_s[e]); end
         tick();
      end
      readyRS_i = '0;
      canGo_i = 1'b0;
      #1;
   endtask

   task automatic test_flush_busy();
      set_station(0, 64'd50, 64'd5, 10'd7, TW'(9));
      readyRS_i = 2'b01;
      #1;
      rr_m = (exp_gnt(readyRS_i) + 1) % NUM_REQ;
      tick();
      readyRS_i = '0;
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      tick();
      pulse_div(64'd10);
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy valid %b busy %b exp 0/0", valid_o, busy_o); end
      set_station(1, 64'd64, 64'd8, 10'd3, TW'(11));
      readyRS_i = 2'b10;
      #1;
      checks++; if (grant_o !== onehot(exp_gnt(readyRS_i))) begin errors++; $display("FAIL flush_next_grant got %b exp %b", grant_o, onehot(exp_gnt(readyRS_i))); end
      rr_m = (exp_gnt(readyRS_i) + 1) % NUM_REQ;
      tick();
      readyRS_i = '0;
      tick();
      pulse_div(div_model(64'd64, 64'd8));
      checks++; if (valid_o !== 1'b1 || executeVal_o !== 64'd8 || executeTag_o !== TW'(11)) begin
         errors++; $display("FAIL flush_next_result valid %b val %0d tag %0d exp 1/8/11", valid_o, executeVal_o, executeTag_o); end
      canGo_i = 1'b1;
      tick();
      canGo_i = 1'b0;
      #1;
   endtask

   task automatic test_flush_edges();
      set_station(0, 64'd30, 64'd6, 10'd4, TW'(2));
      readyRS_i = 2'b01;
      #1;
      rr_m = (exp_gnt(readyRS_i) + 1) % NUM_REQ;
      tick();
      readyRS_i = '0;
      tick();
      flush_i = 1'b1;
      pulse_div(64'd5);
      flush_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_coincident valid %b busy %b exp 0/0", valid_o, busy_o); end
      readyRS_i = 2'b01;
      #1;
      rr_m = (exp_gnt(readyRS_i) + 1) % NUM_REQ;
      tick();
      readyRS_i = '0;
      tick();
      pulse_div(div_model(64'd30, 64'd6));
      checks++; if (valid_o !== 1'b1 || executeVal_o !== 64'd5) begin errors++; $display("FAIL flush_after_coincident valid %b val %0d exp 1/5", valid_o, executeVal_o); end
      flush_i = 1'b1;
      canGo_i = 1'b1;
      tick();
      flush_i = 1'b0;
      canGo_i = 1'b0;
      #1;
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_done valid %b busy %b exp 0/0", valid_o, busy_o); end
      pulse_div(64'd99);
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0 || executeVal_o !== 64'd5) begin
         errors++; $display("FAIL idle_ignore valid %b busy %b val %0d exp 0/0/5", valid_o, busy_o, executeVal_o); end
   endtask

   task automatic test_div_zero();
      set_station(1, 64'd9, 64'd0, 10'd5, TW'(20));
      readyRS_i = 2'b10;
      #1;
      rr_m = (exp_gnt(readyRS_i) + 1) % NUM_REQ;
      tick();
      readyRS_i = '0;
      repeat (3) tick();
      pulse_div(div_model(64'd9, 64'd0));
      checks++; if (valid_o !== 1'b1 || executeFlags_o !== 4'b0001 || executeVal_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++; $display("FAIL divzero flags %b val %h valid %b exp 0001/ffffffffffffffff/1", executeFlags_o, executeVal_o, valid_o); end
      canGo_i = 1'b1;
      tick();
      canGo_i = 1'b0;
      set_station(1, 64'd7, 64'd7, 10'd6, TW'(21));
      readyRS_i = 2'b10;
      #1;
      rr_m = (exp_gnt(readyRS_i) + 1) % NUM_REQ;
      tick();
      readyRS_i = '0;
      tick();
      pulse_div(div_model(64'd7, 64'd7));
      checks++; if (executeFlags_o !== 4'b0000 || executeVal_o !== 64'd1) begin errors++; $display("FAIL div_after_zero flags %b val %0d exp 0000/1", executeFlags_o, executeVal_o); end
      canGo_i = 1'b1;
      tick();
      canGo_i = 1'b0;
      #1;
   endtask

   task automatic test_reset_mid_busy();
      set_station(1, 64'd40, 64'd4, 10'd8, TW'(1));
      set_station(0, 64'd12, 64'd4, 10'd9, TW'(4));
      readyRS_i = 2'b10;
      #1;
      tick();
      readyRS_i = '0;
      #2;
      reset_i = 1'b1;
      #1;
      checks++; if (busy_o !== 1'b0 || valid_o !== 1'b0 || grant_o !== '0) begin
         errors++; $display("FAIL reset_mid_busy busy %b valid %b grant %b exp 0/0/00", busy_o, valid_o, grant_o); end
      #3;
      reset_i = 1'b0;
      rr_m = 0;
      tick();
      pulse_div(64'd10);
      checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_ignore valid %b busy %b exp 0/0", valid_o, busy_o); end
      readyRS_i = 2'b11;
      #1;
      checks++; if (grant_o !== onehot(exp_gnt(readyRS_i))) begin errors++; $display("FAIL reset_rrptr got %b exp %b", grant_o, onehot(exp_gnt(readyRS_i))); end
      readyRS_i = '0;
      #1;
   endtask

   task automatic test_random();
      int e, lat, hold;
      logic [NUM_REQ-1:0] rdy;
      logic [63:0] q;
      bit do_flush;
      for (int n = 0; n < 12; n++) begin
         for (int s = 0; s < NUM_REQ; s++)
            set_station(s, {$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 64'd0 : 64'($urandom_range(1, 5000)),
                        10'($urandom), TW'($urandom_range(0, ROBsize - 1)));
         rdy = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
         readyRS_i = rdy;
         #1;
         e = exp_gnt(rdy);
         checks++; if (grant_o !== onehot(e) || divDivisor_o !== b_s[e] || divDividend_o !== a_s[e]) begin
            errors++; $display("FAIL rand_grant op %0d got %b/%h/%h exp %b/%h/%h", n, grant_o, divDividend_o, divDivisor_o, onehot(e), a_s[e], b_s[e]); end
         rr_m = (e + 1) % NUM_REQ;
         tick();
         readyRS_i = '0;
         lat = $urandom_range(1, 5);
         do_flush = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < lat; c++) begin
            flush_i = do_flush && (c == 0);
            tick();
         end
         flush_i = 1'b0;
         q = div_model(a_s[e], b_s[e]);
         pulse_div(q);
         if (do_flush) begin
            checks++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rand_flush op %0d valid %b busy %b exp 0/0", n, valid_o, busy_o); end
         end else begin
            checks++; if (valid_o !== 1'b1 || executeVal_o !== q || executeTag_o !== t_s[e] || executeCommands_o !== c_s[e]
                          || executeFlags_o !== {3'b000, b_s[e] == 64'd0}) begin
               errors++; $display("FAIL rand_result op %0d valid %b val %h tag %0d cmd %0d flags %b exp 1/%h/%0d/%0d/%b",
                                  n, valid_o, executeVal_o, executeTag_o, executeCommands_o, executeFlags_o, q, t_s[e], c_s[e], {3'b000, b_s[e] == 64'd0}); end
            hold = $urandom_range(0, 2);
            repeat (hold) tick();
            canGo_i = 1'b1;
            tick();
            canGo_i = 1'b0;
            #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_flush_busy();
      test_flush_edges();
      test_div_zero();
      test_reset_mid_busy();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
